// File: rtl/uart_ram_loader.sv
// uart_ram_loader: receives 8N1 UART bytes, recognises a framed load command
// (sync byte, 16-bit little-endian word count, then payload words) and writes
// the assembled little-endian words sequentially into a RAM write port.
module uart_ram_loader #(
    parameter int         CLKS_PER_BIT = 434,
    parameter int         DATA_WIDTH   = 16,
    parameter int         ADDR_WIDTH   = 10,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
    input  logic                  CLK_50,
    input  logic                  reset,
    input  logic                  rx,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  frame_err
);

    localparam int BYTES_PER_WORD = DATA_WIDTH / 8;
    localparam int HALF_BIT       = CLKS_PER_BIT / 2;
    localparam int CNT_W          = $clog2(CLKS_PER_BIT);
    localparam int IDX_W          = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rxState_t;
    typedef enum logic [1:0] {L_SYNC, L_CNT_LO, L_CNT_HI, L_DATA} loadState_t;

    logic             r_rxMeta;
    logic             r_rxSync;

    rxState_t         r_rxState;
    logic [CNT_W-1:0] r_clkCnt;
    logic [2:0]       r_bitIdx;
    logic [7:0]       r_rxByte;
    logic             r_byteValid;
    logic             r_byteErr;

    loadState_t            r_loadState;
    logic [15:0]           r_count;
    logic [IDX_W-1:0]      r_byteIdx;
    logic [DATA_WIDTH-1:0] r_assemble;
    logic [DATA_WIDTH-1:0] w_nextWord;

    // New bytes enter at the top and shift down, so the first byte of a word ends up in [7:0].
    assign w_nextWord = (r_assemble >> 8) | (DATA_WIDTH'(r_rxByte) << (DATA_WIDTH - 8));

    // Two-flop synchronizer for the asynchronous serial line, idling high.
    always_ff @(posedge CLK_50) begin
        if (reset) begin
            r_rxMeta <= 1'b1;
            r_rxSync <= 1'b1;
        end else begin
            r_rxMeta <= rx;
            r_rxSync <= r_rxMeta;
        end
    end

    // UART receiver: find the start bit centre, then sample data and stop bits one bit period apart.
    always_ff @(posedge CLK_50) begin
        if (reset) begin
            r_rxState   <= R_IDLE;
            r_clkCnt    <= '0;
            r_bitIdx    <= '0;
            r_rxByte    <= '0;
            r_byteValid <= 1'b0;
            r_byteErr   <= 1'b0;
        end else begin
            r_byteValid <= 1'b0;
            r_byteErr   <= 1'b0;
            case (r_rxState)
                R_IDLE: begin
                    if (!r_rxSync) begin
                        r_rxState <= R_START;
                        r_clkCnt  <= '0;
                        r_bitIdx  <= '0;
                    end
                end
                R_START: begin
                    if (r_clkCnt == CNT_W'(HALF_BIT - 1)) begin
                        r_clkCnt  <= '0;
                        r_rxState <= r_rxSync ? R_IDLE : R_DATA;
                    end else begin
                        r_clkCnt <= r_clkCnt + CNT_W'(1);
                    end
                end
                R_DATA: begin
                    if (r_clkCnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                        r_clkCnt <= '0;
                        r_rxByte <= {r_rxSync, r_rxByte[7:1]};
                        if (r_bitIdx == 3'd7) begin
                            r_rxState <= R_STOP;
                        end else begin
                            r_bitIdx <= r_bitIdx + 3'd1;
                        end
                    end else begin
                        r_clkCnt <= r_clkCnt + CNT_W'(1);
                    end
                end
                R_STOP: begin
                    if (r_clkCnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                        r_clkCnt    <= '0;
                        r_rxState   <= R_IDLE;
                        r_byteValid <= r_rxSync;
                        r_byteErr   <= !r_rxSync;
                    end else begin
                        r_clkCnt <= r_clkCnt + CNT_W'(1);
                    end
                end
                default: r_rxState <= R_IDLE;
            endcase
        end
    end

    // Loader: parse sync/count/payload, write whole words, and abort on a bad stop bit.
    always_ff @(posedge CLK_50) begin
        if (reset) begin
            r_loadState <= L_SYNC;
            r_count     <= '0;
            r_byteIdx   <= '0;
            r_assemble  <= '0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;
            case (r_loadState)
                L_SYNC: begin
                    if (r_byteErr) begin
                        frame_err <= 1'b1;
                    end else if (r_byteValid && (r_rxByte == SYNC_BYTE)) begin
                        busy        <= 1'b1;
                        frame_err   <= 1'b0;
                        wr_addr     <= '0;
                        r_loadState <= L_CNT_LO;
                    end
                end
                L_CNT_LO: begin
                    if (r_byteErr) begin
                        busy        <= 1'b0;
                        frame_err   <= 1'b1;
                        r_loadState <= L_SYNC;
                    end else if (r_byteValid) begin
                        r_count[7:0] <= r_rxByte;
                        r_loadState  <= L_CNT_HI;
                    end
                end
                L_CNT_HI: begin
                    if (r_byteErr) begin
                        busy        <= 1'b0;
                        frame_err   <= 1'b1;
                        r_loadState <= L_SYNC;
                    end else if (r_byteValid) begin
                        if ({r_rxByte, r_count[7:0]} == 16'd0) begin
                            done        <= 1'b1;
                            busy        <= 1'b0;
                            r_loadState <= L_SYNC;
                        end else begin
                            r_count     <= {r_rxByte, r_count[7:0]};
                            r_byteIdx   <= '0;
                            r_loadState <= L_DATA;
                        end
                    end
                end
                L_DATA: begin
                    if (wr_en) begin
                        wr_addr <= wr_addr + ADDR_WIDTH'(1);
                        if (r_count == 16'd0) begin
                            done        <= 1'b1;
                            busy        <= 1'b0;
                            r_loadState <= L_SYNC;
                        end
                    end else if (r_byteErr) begin
                        busy        <= 1'b0;
                        frame_err   <= 1'b1;
                        r_loadState <= L_SYNC;
                    end else if (r_byteValid) begin
                        if (r_byteIdx == IDX_W'(BYTES_PER_WORD - 1)) begin
                            wr_data   <= w_nextWord;
                            wr_en     <= 1'b1;
                            r_count   <= r_count - 16'd1;
                            r_byteIdx <= '0;
                        end else begin
                            r_assemble <= w_nextWord;
                            r_byteIdx  <= r_byteIdx + IDX_W'(1);
                        end
                    end
                end
                default: r_loadState <= L_SYNC;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_ram_loader.sv
// Testbench for uart_ram_loader: two instances (10-bit and 2-bit address) share
// one serial line; writes are collected and compared with a frame-level model.
module tb_uart_ram_loader;

    localparam int CPB = 4;

    logic        CLK_50 = 1'b0;
    logic        reset  = 1'b1;
    logic        rx     = 1'b1;

    logic        wrEnA, busyA, doneA, errA;
    logic [9:0]  addrA;
    logic [15:0] dataA;
    logic        wrEnB, busyB, doneB, errB;
    logic [1:0]  addrB;
    logic [15:0] dataB;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    typedef struct {
        int               nBytes;
        logic [0:15][7:0] b;
        int               errIdx;
        int               expWrites;
        int               expDone;
        int               expErr;
        int               lastAddrB;
        int               lastData;
    } vec_t;

    wr_t        gotA[$], gotB[$], expA[$], expB[$], modelQ[$];
    logic [7:0] stimB[$];
    bit         stimOk[$];
    vec_t       vecs[7];

    int total = 0;
    int bad   = 0;
    int doneCntA = 0, doneCntB = 0;
    bit mErr = 1'b0;
    logic prevWrA = 1'b0, prevWrB = 1'b0, prevBusyA = 1'b0, prevBusyB = 1'b0;

    uart_ram_loader #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(16), .ADDR_WIDTH(10), .SYNC_BYTE(8'hA5)) dutA (
        .CLK_50(CLK_50), .reset(reset), .rx(rx),
        .wr_en(wrEnA), .wr_addr(addrA), .wr_data(dataA),
        .busy(busyA), .done(doneA), .frame_err(errA)
    );

    uart_ram_loader #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(16), .ADDR_WIDTH(2), .SYNC_BYTE(8'hA5)) dutB (
        .CLK_50(CLK_50), .reset(reset), .rx(rx),
        .wr_en(wrEnB), .wr_addr(addrB), .wr_data(dataB),
        .busy(busyB), .done(doneB), .frame_err(errB)
    );

    // Free-running system clock.
    always #5 CLK_50 = ~CLK_50;

    task automatic checkOutput(input string name, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Collect writes and done pulses on the falling edge, and check pulse spacing rules.
    always @(negedge CLK_50) begin
        wr_t w;
        if (reset) begin
            prevWrA = 1'b0; prevWrB = 1'b0; prevBusyA = 1'b0; prevBusyB = 1'b0;
        end else begin
            if (wrEnA) begin
                w.addr = int'(addrA); w.data = int'(dataA); gotA.push_back(w);
            end
            if (wrEnB) begin
                w.addr = int'(addrB); w.data = int'(dataB); gotB.push_back(w);
            end
            if (doneA) doneCntA++;
            if (doneB) doneCntB++;
            if (wrEnA || doneA) begin
                checkOutput("wrSpacingA", int'(wrEnA && prevWrA), 0);
                checkOutput("doneWithWrA", int'(wrEnA && doneA), 0);
            end
            if (wrEnB || doneB) begin
                checkOutput("wrSpacingB", int'(wrEnB && prevWrB), 0);
                checkOutput("doneWithWrB", int'(wrEnB && doneB), 0);
            end
            if (doneA) checkOutput("busyFallA", int'({prevBusyA, busyA}), 2);
            if (doneB) checkOutput("busyFallB", int'({prevBusyB, busyB}), 2);
            prevWrA = wrEnA; prevWrB = wrEnB; prevBusyA = busyA; prevBusyB = busyB;
        end
    end

    task automatic holdBit(input logic v);
        @(posedge CLK_50);
        #1 rx = v;
        repeat (CPB - 1) @(posedge CLK_50);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK_50);
    endtask

    // Send one 8N1 byte (stop bit low when ok is 0) and record it for the model.
    task automatic applyStimulus(input logic [7:0] b, input bit ok);
        stimB.push_back(b);
        stimOk.push_back(ok);
        holdBit(1'b0);
        for (int i = 0; i < 8; i++) holdBit(b[i]);
        holdBit(ok);
        holdBit(1'b1);
        holdBit(1'b1);
    endtask

    task automatic clearRun();
        stimB.delete(); stimOk.delete();
        gotA.delete(); gotB.delete();
        doneCntA = 0; doneCntB = 0;
    endtask

    task automatic takeByte(inout int idx, inout bit good, output int val);
        val = 0;
        if (idx >= stimB.size()) begin
            good = 1'b0;
        end else begin
            val = int'(stimB[idx]);
            if (!stimOk[idx]) good = 1'b0;
            idx++;
        end
    endtask

    // Frame-level model: scan the byte stream for sync, read count, emit words.
    task automatic modelRun(input int aw, input bit startErr, output int nDone, output bit endErr, output bit endBusy);
        int i = 0;
        int lo, hi, b0, b1, n;
        bit good;
        wr_t w;
        modelQ.delete();
        nDone = 0; endErr = startErr; endBusy = 1'b0;
        while (i < stimB.size()) begin
            if (!stimOk[i]) begin
                endErr = 1'b1; i++;
            end else if (stimB[i] != 8'hA5) begin
                i++;
            end else begin
                i++;
                endErr = 1'b0;
                good = 1'b1;
                takeByte(i, good, lo);
                if (good) takeByte(i, good, hi);
                if (good) begin
                    n = lo + hi * 256;
                    for (int k = 0; k < n && good; k++) begin
                        takeByte(i, good, b0);
                        if (good) takeByte(i, good, b1);
                        if (good) begin
                            w.addr = k % (1 << aw);
                            w.data = b0 + b1 * 256;
                            modelQ.push_back(w);
                        end
                    end
                end
                if (good) nDone++;
                else endErr = 1'b1;
            end
        end
    endtask

    task automatic runAndCheck(input string name, input int expWrites, input int expDone, input int expErr,
                               input int lastAddrB, input int lastData);
        int dA, dB;
        bit eA, eB, bA, bB;
        modelRun(10, mErr, dA, eA, bA);
        expA = modelQ;
        modelRun(2, mErr, dB, eB, bB);
        expB = modelQ;
        mErr = eA;
        checkOutput($sformatf("%s.nWrA", name), gotA.size(), expA.size());
        checkOutput($sformatf("%s.nWrB", name), gotB.size(), expB.size());
        for (int k = 0; k < gotA.size() && k < expA.size(); k++) begin
            checkOutput($sformatf("%s.addrA[%0d]", name, k), gotA[k].addr, expA[k].addr);
            checkOutput($sformatf("%s.dataA[%0d]", name, k), gotA[k].data, expA[k].data);
        end
        for (int k = 0; k < gotB.size() && k < expB.size(); k++) begin
            checkOutput($sformatf("%s.addrB[%0d]", name, k), gotB[k].addr, expB[k].addr);
            checkOutput($sformatf("%s.dataB[%0d]", name, k), gotB[k].data, expB[k].data);
        end
        @(negedge CLK_50);
        checkOutput($sformatf("%s.doneA", name), doneCntA, dA);
        checkOutput($sformatf("%s.doneB", name), doneCntB, dB);
        checkOutput($sformatf("%s.errA", name), int'(errA), int'(eA));
        checkOutput($sformatf("%s.errB", name), int'(errB), int'(eB));
        checkOutput($sformatf("%s.busyA", name), int'(busyA), int'(bA));
        checkOutput($sformatf("%s.busyB", name), int'(busyB), int'(bB));
        if (expWrites >= 0) begin
            checkOutput($sformatf("%s.tblWr", name), gotA.size(), expWrites);
            checkOutput($sformatf("%s.tblDone", name), doneCntA, expDone);
            checkOutput($sformatf("%s.tblErr", name), int'(errA), expErr);
        end
        if (lastAddrB >= 0 && gotB.size() > 0) begin
            checkOutput($sformatf("%s.tblLastAddrB", name), gotB[gotB.size()-1].addr, lastAddrB);
            checkOutput($sformatf("%s.tblLastData", name), gotA[gotA.size()-1].data, lastData);
        end
    endtask

    task automatic checkResetOutputs(input string name);
        checkOutput($sformatf("%s.wrEnA", name), int'(wrEnA), 0);
        checkOutput($sformatf("%s.addrA", name), int'(addrA), 0);
        checkOutput($sformatf("%s.dataA", name), int'(dataA), 0);
        checkOutput($sformatf("%s.busyA", name), int'(busyA), 0);
        checkOutput($sformatf("%s.doneA", name), int'(doneA), 0);
        checkOutput($sformatf("%s.errA", name), int'(errA), 0);
        checkOutput($sformatf("%s.wrEnB", name), int'(wrEnB), 0);
        checkOutput($sformatf("%s.addrB", name), int'(addrB), 0);
        checkOutput($sformatf("%s.dataB", name), int'(dataB), 0);
        checkOutput($sformatf("%s.busyB", name), int'(busyB), 0);
    endtask

    initial begin
        int nNoise, nWords, errPos, pos, v;

        vecs[0] = '{7,  {8'hA5, 8'h02, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB, 72'h0}, -1, 2, 1, 0, 1, 16'hABCD};
        vecs[1] = '{5,  {8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 88'h0}, -1, 0, 1, 0, -1, 0};
        vecs[2] = '{6,  {8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 80'h0}, 5, 1, 0, 1, 0, 16'h2211};
        vecs[3] = '{3,  {8'hA5, 8'h00, 8'h00, 104'h0}, -1, 0, 1, 0, -1, 0};
        vecs[4] = '{13, {8'hA5, 8'h05, 8'h00, 8'h11, 8'h01, 8'h22, 8'h02, 8'h33, 8'h03,
                         8'h44, 8'h04, 8'h55, 8'h05, 24'h0}, -1, 5, 1, 0, 0, 16'h0555};
        vecs[5] = '{6,  {8'h00, 8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 80'h0}, 0, 1, 1, 0, 0, 16'h5678};
        vecs[6] = '{5,  {8'hA5, 8'h01, 8'h00, 8'hA5, 8'hA5, 88'h0}, -1, 1, 1, 0, 0, 16'hA5A5};

        idle(3);
        @(negedge CLK_50);
        checkResetOutputs("reset");
        @(posedge CLK_50);
        #1 reset = 1'b0;
        idle(5);

        for (int t = 0; t < 7; t++) begin
            clearRun();
            for (int k = 0; k < vecs[t].nBytes; k++) applyStimulus(vecs[t].b[k], k != vecs[t].errIdx);
            idle(30);
            runAndCheck($sformatf("vec%0d", t), vecs[t].expWrites, vecs[t].expDone, vecs[t].expErr,
                        vecs[t].lastAddrB, vecs[t].lastData);
        end

        // Start glitch shorter than half a bit, then a one-word frame.
        clearRun();
        @(posedge CLK_50);
        #1 rx = 1'b0;
        @(posedge CLK_50);
        #1 rx = 1'b1;
        idle(12);
        @(negedge CLK_50);
        checkOutput("glitch.busyA", int'(busyA), 0);
        applyStimulus(8'hA5, 1'b1);
        applyStimulus(8'h01, 1'b1);
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'hEF, 1'b1);
        applyStimulus(8'hBE, 1'b1);
        idle(30);
        runAndCheck("glitch", 1, 1, 0, 0, 16'hBEEF);

        // Zero count: busy must be high while the count bytes arrive.
        clearRun();
        applyStimulus(8'hA5, 1'b1);
        @(negedge CLK_50);
        checkOutput("zero.busyCntA", int'(busyA), 1);
        applyStimulus(8'h00, 1'b1);
        @(negedge CLK_50);
        checkOutput("zero.busyCntB", int'(busyB), 1);
        applyStimulus(8'h00, 1'b1);
        idle(20);
        runAndCheck("zero", 0, 1, 0, -1, 0);

        // Randomized frames with optional noise and injected stop-bit errors.
        for (int r = 0; r < 10; r++) begin
            clearRun();
            nNoise = $urandom_range(0, 2);
            for (int k = 0; k < nNoise; k++) begin
                v = $urandom_range(0, 255);
                if (v == 8'hA5) v = 0;
                applyStimulus(8'(v), $urandom_range(0, 4) != 0);
            end
            nWords = $urandom_range(0, 3);
            errPos = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1 + 2 * nWords) : -1;
            applyStimulus(8'hA5, 1'b1);
            pos = 0;
            while (pos < 2 + 2 * nWords) begin
                if (pos == 0) v = nWords;
                else if (pos == 1) v = 0;
                else v = $urandom_range(0, 255);
                applyStimulus(8'(v), pos != errPos);
                if (pos == errPos) break;
                pos++;
            end
            idle(30);
            runAndCheck($sformatf("rnd%0d", r), -1, 0, 0, -1, 0);
        end

        // Reset in the middle of a frame, then the rest of the stream without a sync byte.
        clearRun();
        applyStimulus(8'hA5, 1'b1);
        applyStimulus(8'h02, 1'b1);
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'h34, 1'b1);
        applyStimulus(8'h12, 1'b1);
        idle(6);
        checkOutput("rstMid.preWr", gotA.size(), 1);
        if (gotA.size() > 0) checkOutput("rstMid.preData", gotA[0].data, 16'h1234);
        @(posedge CLK_50);
        #1 reset = 1'b1;
        @(posedge CLK_50);
        #1 reset = 1'b0;
        @(negedge CLK_50);
        checkResetOutputs("rstMid");
        clearRun();
        mErr = 1'b0;
        applyStimulus(8'hCD, 1'b1);
        applyStimulus(8'hAB, 1'b1);
        idle(30);
        runAndCheck("rstTail", 0, 0, 0, -1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
